// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller blocks: arbiter state encoding,
// default sizing and the engine start-acknowledge timeout.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_e;

  localparam int NUM_REQ_DEF       = 4;
  localparam int ID_W              = $clog2(NUM_REQ_DEF);
  localparam int START_TIMEOUT_DEF = 16;

  // Index after idx, wrapping back to 0 at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set bit of valid_i at or after ptr_i,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX engine among NUM_REQ byte producers,
// with grant hold across multi-byte messages and a start-acknowledge timeout.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int GID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      grant_active,
  output logic                      err_timeout
);

  localparam int               CNT_W   = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic              gact_q, gact_d;
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [GID_W-1:0]   pick_idx;
  logic               pick_any;
  logic [GID_W-1:0]   ptr_next;

  rr_pick #(.N(NUM_REQ), .IW(GID_W)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Releasing the grant always moves priority just past the owner.
  assign ptr_next = GID_W'(wrap_inc(int'(gid_q), NUM_REQ));

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    last_d    = last_q;
    gid_d     = gid_q;
    gact_d    = gact_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && pick_any) begin
          req_ready = pick_gnt;
          byte_d    = req_data[pick_idx*DATA_W +: DATA_W];
          last_d    = req_last[pick_idx];
          gid_d     = pick_idx;
          gact_d    = 1'b1;
          cnt_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          gact_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            gact_d  = 1'b0;
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Owner keeps the engine even while idle; no timeout applies here.
        if (req_valid[gid_q]) begin
          req_ready[gid_q] = 1'b1;
          byte_d           = req_data[gid_q*DATA_W +: DATA_W];
          last_d           = req_last[gid_q];
          cnt_d            = '0;
          state_d          = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      last_q  <= 1'b0;
      gid_q   <= '0;
      gact_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      gact_q  <= gact_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign tx_start     = (state_q == START);
  assign tx_data      = byte_q;
  assign grant_id     = gid_q;
  assign grant_active = gact_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration table plus hand sequences
// for hold, timeout, async reset and externally held busy.
module tb_uart_tx_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int FRAME = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy;
  logic [1:0]       grant_id;
  logic             grant_active;
  logic             err_timeout;

  logic             eng_busy;
  logic             ext_busy;
  logic             eng_en;
  int               fcnt;
  logic [7:0]       log_q[$];

  int checks = 0;
  int errors = 0;
  int n, blocked, errs_seen;
  logic [7:0] got;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rdy;
    logic [7:0] exp_data;
    logic [1:0] exp_gid;
  } vec_t;
  vec_t tbl[16];
  logic [7:0] h2_exp[4];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .START_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Engine model: accept tx_start, stay busy FRAME cycles, log each byte.
  assign tx_busy = eng_busy | ext_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_busy <= 1'b0;
      fcnt     <= 0;
    end else if (!eng_busy) begin
      if (eng_en && tx_start) begin
        eng_busy <= 1'b1;
        fcnt     <= FRAME;
        log_q.push_back(tx_data);
      end
    end else if (fcnt <= 1) begin
      eng_busy <= 1'b0;
    end else begin
      fcnt <= fcnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((grant_active || tx_busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle_timeout"}, 32'(k >= 200), 0);
  endtask

  task automatic pop_log(output logic [7:0] b);
    b = (log_q.size() > 0) ? log_q.pop_front() : 8'hxx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_last  = 4'hF;
    ext_busy  = 1'b0;
    eng_en    = 1'b1;

    tbl[0]  = '{4'b1111, 4'b0001, 8'h10, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0010, 8'h11, 2'd1};
    tbl[2]  = '{4'b1111, 4'b0100, 8'h12, 2'd2};
    tbl[3]  = '{4'b1111, 4'b1000, 8'h13, 2'd3};
    tbl[4]  = '{4'b1111, 4'b0001, 8'h10, 2'd0};
    tbl[5]  = '{4'b1111, 4'b0010, 8'h11, 2'd1};
    tbl[6]  = '{4'b1111, 4'b0100, 8'h12, 2'd2};
    tbl[7]  = '{4'b1111, 4'b1000, 8'h13, 2'd3};
    tbl[8]  = '{4'b1001, 4'b0001, 8'h10, 2'd0};
    tbl[9]  = '{4'b1001, 4'b1000, 8'h13, 2'd3};
    tbl[10] = '{4'b0110, 4'b0010, 8'h11, 2'd1};
    tbl[11] = '{4'b0011, 4'b0001, 8'h10, 2'd0};
    tbl[12] = '{4'b0001, 4'b0001, 8'h10, 2'd0};
    tbl[13] = '{4'b0001, 4'b0001, 8'h10, 2'd0};
    tbl[14] = '{4'b0101, 4'b0100, 8'h12, 2'd2};
    tbl[15] = '{4'b0101, 4'b0001, 8'h10, 2'd0};
    h2_exp  = '{8'hB0, 8'hB1, 8'hB2, 8'h11};

    // Reset state
    reset_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_gact", grant_active, 0);
    chk("rst_err", err_timeout, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single byte A5 from requester 0
    @(negedge clk);
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    #1 chk("h1_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("h1_start", tx_start, 1);
    chk("h1_data", tx_data, 8'hA5);
    chk("h1_gact", grant_active, 1);
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clk); n++; end
    while (tx_busy && n < 50) begin @(negedge clk); n++; end
    chk("h1_busy_timeout", 32'(n >= 50), 0);
    chk("h1_gact_at_fall", grant_active, 1);
    @(negedge clk);
    chk("h1_gact_after", grant_active, 0);
    pop_log(got);
    chk("h1_engine_byte", got, 8'hA5);
    req_data[7:0] = 8'h10;

    // Fresh reset so the pointer starts at 0 for the table
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid;
      #1 chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_rdy);
      @(negedge clk);
      req_valid = '0;
      chk($sformatf("tbl%0d_start", i), tx_start, 1);
      chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].exp_gid);
      wait_idle($sformatf("tbl%0d", i));
      pop_log(got);
      chk($sformatf("tbl%0d_engine", i), got, tbl[i].exp_data);
    end

    // Requester 2 holds the grant over a 3-byte message; requester 1 waits
    log_q.delete();
    @(negedge clk);
    req_data[23:16] = 8'hB0;
    req_last        = 4'b1011;
    req_valid       = 4'b0100;
    #1 chk("h2_ready0", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0010;
    chk("h2_data0", tx_data, 8'hB0);
    blocked   = 0;
    errs_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (req_ready != 0) blocked++;
      if (err_timeout) errs_seen++;
    end
    chk("h2_hold_no_timeout", errs_seen, 0);
    chk("h2_hold_gact", grant_active, 1);
    chk("h2_hold_gid", grant_id, 2);
    req_data[23:16] = 8'hB1;
    req_valid       = 4'b0110;
    #1 chk("h2_ready1", req_ready, 4'b0100);
    @(negedge clk);
    chk("h2_data1", tx_data, 8'hB1);
    req_data[23:16] = 8'hB2;
    req_last        = 4'b1111;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      if (req_ready[1]) blocked++;
      n++;
    end while (!req_ready[2] && n < 50);
    chk("h2_ready2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0010;
    chk("h2_data2", tx_data, 8'hB2);
    n = 0;
    @(negedge clk);
    #1;
    while (grant_active && n < 100) begin
      if (req_ready != 0) blocked++;
      @(negedge clk);
      #1;
      n++;
    end
    chk("h2_r1_blocked", blocked, 0);
    chk("h2_r1_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("h2_r1_gid", grant_id, 1);
    chk("h2_r1_data", tx_data, 8'h11);
    wait_idle("h2");
    for (int k = 0; k < 4; k++) begin
      pop_log(got);
      chk($sformatf("h2_engine%0d", k), got, h2_exp[k]);
    end

    // Engine never acknowledges: timeout after 16 cycles of tx_start
    eng_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b1001;
    #1 chk("h3_ready", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    n = 0;
    while (tx_start && !err_timeout && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("h3_start_cycles", n, 16);
    chk("h3_err_pulse", err_timeout, 1);
    chk("h3_start_dropped", tx_start, 0);
    chk("h3_gact", grant_active, 0);
    #1 chk("h3_next_ready", req_ready, 4'b0001);
    eng_en = 1'b1;
    @(negedge clk);
    req_valid = '0;
    chk("h3_err_cleared", err_timeout, 0);
    chk("h3_next_data", tx_data, 8'h10);
    chk("h3_next_gid", grant_id, 0);
    wait_idle("h3");
    chk("h3_engine_count", log_q.size(), 1);
    pop_log(got);
    chk("h3_engine_byte", got, 8'h10);

    // Async reset while the engine is mid-frame
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!(tx_busy && !tx_start) && n < 50) begin @(negedge clk); n++; end
    chk("h4_wait_done_reached", 32'(n >= 50), 0);
    #2 reset_n = 1'b0;
    #1 chk("h4_async_outputs", {req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();
    @(negedge clk);
    req_valid = 4'b1111;
    #1 chk("h4_ready_after", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("h4_gid_after", grant_id, 0);
    chk("h4_data_after", tx_data, 8'h10);
    wait_idle("h4");

    // Busy held externally blocks acceptance until it drops
    @(negedge clk);
    ext_busy  = 1'b1;
    req_valid = 4'b0010;
    n = 0;
    repeat (5) begin
      #1;
      if (req_ready != 0) n++;
      @(negedge clk);
    end
    chk("h5_blocked", n, 0);
    @(posedge clk);
    #1 ext_busy = 1'b0;
    @(negedge clk);
    chk("h5_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("h5_start", tx_start, 1);
    chk("h5_data", tx_data, 8'h11);
    wait_idle("h5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one byte-wide UART transmit engine among NUM_REQ independent requesters. Each requester offers bytes on a valid/ready handshake. The block picks a requester round-robin, issues each byte to the engine with a start strobe, and tracks the engine's busy flag through the frame. A requester can hold the grant across a multi-byte message using a last flag. It sits between the software/FSM byte producers and the UART TX engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width passed to the engine
START_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte is final of message; releases grant after it is sent
req_ready  out  NUM_REQ  one-hot byte accept; transfer when valid&ready
tx_start  out  1  start request to engine, held until tx_busy seen high
tx_data  out  DATA_W  byte to engine, stable while tx_start or tx_busy is high
tx_busy  in  1  engine busy, high for the whole frame
grant_id  out  $clog2(NUM_REQ)  current/last owner index
grant_active  out  1  a requester owns the engine (message in progress)
err_timeout  out  1  one-cycle pulse: engine never acknowledged tx_start

Behaviour:
- Reset (async, reset_n=0): state IDLE. req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, err_timeout=0. RR pointer=0, so requester 0 has first priority. Reset mid-frame abandons the byte silently.
- FSM states: IDLE, START, WAIT_DONE, HOLD.
- IDLE:
  - If tx_busy=0 and any req_valid is set, the winner w is the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[w]=1 combinationally in the same cycle. The byte and req_last[w] are latched; grant_id<=w; grant_active<=1. Next state START.
  - If tx_busy=1, no ready is given.
- START:
  - tx_start=1; tx_data holds the latched byte.
  - When tx_busy is sampled 1, go to WAIT_DONE and drop tx_start the same edge.
  - A wait counter runs from 0. If it reaches START_TIMEOUT-1 without tx_busy: drop tx_start, pulse err_timeout for 1 cycle, grant_active<=0, pointer<=w+1, go to IDLE. The byte is lost.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If the latched last=1: grant_active<=0, pointer<=w+1 (wraps), go to IDLE.
  - Otherwise go to HOLD.
- HOLD:
  - req_ready[w]=req_valid[w] only; all other requesters are blocked indefinitely.
  - On transfer, latch the byte and last flag and go to START.
- Latency: accept to tx_start = 1 cycle. tx_busy fall to next accept = 1 cycle (IDLE or HOLD).
- req_ready is never asserted in START or WAIT_DONE. At most one bit is ever set.
- A single requester streaming with last=1 on every byte still alternates fairly with other valid requesters.
- A requester that deasserts valid in HOLD is not timed out; the grant stays held.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum (IDLE/START/WAIT_DONE/HOLD)
  - the default NUM_REQ
  - localparam ID_W = $clog2(NUM_REQ)
  - the START_TIMEOUT default, shared with other UART controllers
- One sub-module, rr_pick: a combinational rotating-priority selector with inputs valid vector and pointer, and outputs one-hot grant, index, and any. It is reused by future RX-side schedulers.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'hA5, last=1 → req_ready[0] that cycle; tx_start next cycle with tx_data=A5. Engine busy 1..N → grant_active falls 1 cycle after tx_busy falls.
- All 4 valid with last=1, bytes 10/11/12/13 → engine sees 10, 11, 12, 13 in order. Repeat: order 10, 11, 12, 13 again, because the pointer wraps after 3.
- Requester 2 sends 3 bytes (last=0, 0, 1) while requester 1 is valid → requester 1 gets no ready until requester 2's third byte completes. Then grant_id=1.
- Engine model never raises tx_busy → tx_start drops and err_timeout pulses exactly 16 cycles after tx_start rose. The next requester is served.
- Assert reset_n=0 during WAIT_DONE → all outputs 0 asynchronously. After release, requester 0 is served first.
- tx_busy=1 held externally while requests are pending → no req_ready until tx_busy=0, then an accept on the following cycle.
